counting_sched: RTL and testbench

Round-robin packet scheduler in front of the `counting` sequence detector. Two requesters each stream packets of 2-bit symbols; the block grants one packet at a time, without interleaving, since the detector is stateful. It separates packets with flush symbols, counts detector hits per packet and reports the count with the packet's source ID. It sits between the symbol producers and the detector's `num`/`ans` pins and is the only driver of `num`.

---
 rtl/counting_pkg.sv | 13 +
 rtl/counting_sched_rr_arb2.sv | 24 ++
 rtl/counting_sched.sv | 125 ++++++++++++
 tb/tb_counting_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counting_pkg.sv
// Shared types and constants for the counting-detector scheduler.
package counting_pkg;
  localparam int SYM_W = 2;
  localparam logic [SYM_W-1:0] FLUSH_SYM = 2'b00;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_REPORT
  } state_t;
endpackage

// File: rtl/counting_sched_rr_arb2.sv
// Two-way round-robin picker; combinational pick, last-served pointer advances on take.
// No backpressure of its own: the caller decides when a pick is consumed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any,
  output logic       pick
);
  logic last;

  assign any  = |req;
  // On a tie the requester not served last wins; otherwise the lone requester.
  assign pick = (req[0] && req[1]) ? ~last : req[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take && any) begin
      last <= pick;
    end
  end
endmodule

// File: rtl/counting_sched.sv
// Packet-level round-robin scheduler feeding the counting detector; grant 1 cycle after IDLE sees valid.
// Only the granted requester sees ready, and only in STREAM; reports are registered one-cycle pulses.
module counting_sched
  import counting_pkg::*;
#(
  parameter int FLUSH_LEN = 2,
  parameter int DET_LAT   = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [SYM_W-1:0] req0_num,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [SYM_W-1:0] req1_num,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic [SYM_W-1:0] det_num,
  input  logic             det_ans,
  output logic             done_valid,
  output logic             done_src,
  output logic [CNT_W-1:0] done_hits
);
  localparam int FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  state_t           state;
  logic [FC_W-1:0]  fcnt;
  logic             gnt;
  logic [SYM_W-1:0] hold_sym;
  logic [DET_LAT-1:0] win;
  logic [CNT_W-1:0] hits;
  logic [CNT_W-1:0] hits_nxt;
  logic             arb_any;
  logic             arb_pick;
  logic             in_stream;
  logic             g_valid;
  logic             g_last;
  logic [SYM_W-1:0] g_num;

  assign in_stream  = (state == ST_STREAM);
  assign g_valid    = gnt ? req1_valid : req0_valid;
  assign g_last     = gnt ? req1_last  : req0_last;
  assign g_num      = gnt ? req1_num   : req0_num;
  // Gating with rst_n keeps an abandoned packet from being accepted in the reset cycle.
  assign req0_ready = rst_n && in_stream && !gnt;
  assign req1_ready = rst_n && in_stream && gnt;

  always_comb begin
    det_num = FLUSH_SYM;
    if (rst_n && in_stream) begin
      det_num = g_valid ? g_num : hold_sym;
    end
  end

  assign hits_nxt = (win[DET_LAT-1] && det_ans && (hits != HIT_MAX)) ? hits + CNT_W'(1) : hits;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({req1_valid, req0_valid}),
    .take (state == ST_IDLE),
    .any  (arb_any),
    .pick (arb_pick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      fcnt       <= '0;
      gnt        <= 1'b0;
      hold_sym   <= FLUSH_SYM;
      win        <= '0;
      hits       <= '0;
      done_valid <= 1'b0;
      done_src   <= 1'b0;
      done_hits  <= '0;
    end else begin
      // Every STREAM cycle, hold or not, opens one slot of the answer window.
      win        <= (win << 1) | DET_LAT'(in_stream);
      hits       <= hits_nxt;
      done_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (fcnt == FC_LAST) begin
            fcnt  <= '0;
            state <= ST_IDLE;
          end else begin
            fcnt <= fcnt + FC_W'(1);
          end
        end
        ST_IDLE: begin
          if (arb_any) begin
            gnt      <= arb_pick;
            hold_sym <= FLUSH_SYM;
            hits     <= '0;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (g_valid) begin
            hold_sym <= g_num;
            if (g_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fcnt == FC_LAST) begin
            fcnt       <= '0;
            state      <= ST_REPORT;
            done_valid <= 1'b1;
            done_src   <= gnt;
            done_hits  <= hits_nxt;
          end else begin
            fcnt <= fcnt + FC_W'(1);
          end
        end
        ST_REPORT: state <= ST_IDLE;
        default:   state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_counting_sched.sv
// Bench for counting_sched: two DUTs (CNT_W 8 and 2) share stimulus; a timeline model checks every cycle.
module tb_counting_sched;
  localparam int FLUSH_LEN = 2;
  localparam int DET_LAT   = 1;

  typedef struct {
    logic [1:0] num;
    bit         last;
    int         gap;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] vld = '0;
  logic [1:0] lst = '0;
  logic [1:0] nm [2] = '{2'b00, 2'b00};
  logic       ans_force = 1'b0;

  logic [1:0] rdy8, rdy2;
  logic [1:0] det_num8, det_num2;
  logic       done_v8, done_v2, done_s8, done_s2;
  logic [7:0] done_h8;
  logic [1:0] done_h2;

  // Stand-in detector: one hit when det_num changes to 3, seen one cycle later.
  logic [1:0] prev8 = 2'b00, prev2 = 2'b00;
  logic       ans8_r = 1'b0, ans2_r = 1'b0;
  logic       ans8, ans2;
  always @(posedge clk) begin
    ans8_r <= (det_num8 == 2'd3) && (prev8 != 2'd3);
    prev8  <= det_num8;
    ans2_r <= (det_num2 == 2'd3) && (prev2 != 2'd3);
    prev2  <= det_num2;
  end
  assign ans8 = ans8_r | ans_force;
  assign ans2 = ans2_r | ans_force;

  counting_sched #(.FLUSH_LEN(FLUSH_LEN), .DET_LAT(DET_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[0]), .req0_num(nm[0]), .req0_last(lst[0]), .req0_ready(rdy8[0]),
    .req1_valid(vld[1]), .req1_num(nm[1]), .req1_last(lst[1]), .req1_ready(rdy8[1]),
    .det_num(det_num8), .det_ans(ans8),
    .done_valid(done_v8), .done_src(done_s8), .done_hits(done_h8)
  );

  counting_sched #(.FLUSH_LEN(FLUSH_LEN), .DET_LAT(DET_LAT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(vld[0]), .req0_num(nm[0]), .req0_last(lst[0]), .req0_ready(rdy2[0]),
    .req1_valid(vld[1]), .req1_num(nm[1]), .req1_last(lst[1]), .req1_ready(rdy2[1]),
    .det_num(det_num2), .det_ans(ans2),
    .done_valid(done_v2), .done_src(done_s2), .done_hits(done_h2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, act, exp);
    end
  endtask

  // ---------------- requester drivers ----------------
  ent_t q0[$], q1[$];
  ent_t cur[2];
  bit [1:0] have = '0;
  int gap_left[2] = '{0, 0};
  bit [1:0] acc = '0;

  task automatic push(input int r, input logic [1:0] num, input bit last, input int gap);
    ent_t e;
    e.num = num; e.last = last; e.gap = gap;
    if (r == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (!rst_n) begin
          have[r] = 1'b0;
          vld[r]  = 1'b0;
          if (r == 0) q0.delete(); else q1.delete();
        end else begin
          if (have[r] && acc[r]) have[r] = 1'b0;
          if (!have[r]) begin
            if (r == 0 && q0.size() > 0) begin cur[r] = q0.pop_front(); have[r] = 1'b1; gap_left[r] = cur[r].gap; end
            if (r == 1 && q1.size() > 0) begin cur[r] = q1.pop_front(); have[r] = 1'b1; gap_left[r] = cur[r].gap; end
          end
          if (have[r] && gap_left[r] > 0) begin
            gap_left[r]--;
            vld[r] = 1'b0;
          end else begin
            vld[r] = have[r];
            if (have[r]) begin nm[r] = cur[r].num; lst[r] = cur[r].last; end
          end
        end
      end
    end
  end

  // ---------------- timeline model + per-cycle compare ----------------
  int cyc = 0;
  int owner = -1;
  int free_at = 0;
  int report_at = -1;
  bit last_srv = 1'b1;
  bit pk_src = 1'b0;
  logic [1:0] hold = 2'b00;
  bit prev_stream = 1'b0;
  int raw8 = 0, raw2 = 0;
  bit exp_src = 1'b0;
  int exp_h8 = 0, exp_h2 = 0;
  bit rst_low_prev = 1'b0;

  int rep_n = 0;
  int rep_src[16], rep_h8[16], rep_h2[16], rep_lat[16];
  int last_acc_cyc = -1;
  bit next_first = 1'b1;
  int ovh_n = 0;
  int ovh[16];
  int n_acc[2] = '{0, 0};

  initial begin
    logic [1:0] e_rdy;
    logic [1:0] e_num;
    bit g;
    forever begin
      @(negedge clk);
      cyc++;
      acc = vld & rdy8;
      if (!rst_n) begin
        chk("rst_ready8", rdy8, 0);
        chk("rst_ready2", rdy2, 0);
        chk("rst_det_num", det_num8, 0);
        if (rst_low_prev) begin
          chk("rst_done_valid", {done_v8, done_v2}, 0);
          chk("rst_done_src", {done_s8, done_s2}, 0);
          chk("rst_done_hits8", done_h8, 0);
          chk("rst_done_hits2", done_h2, 0);
        end
        rst_low_prev = 1'b1;
        owner = -1; free_at = cyc + 1 + FLUSH_LEN; report_at = -1;
        last_srv = 1'b1; exp_src = 1'b0; exp_h8 = 0; exp_h2 = 0;
        prev_stream = 1'b0; last_acc_cyc = -1; next_first = 1'b1;
      end else begin
        rst_low_prev = 1'b0;
        if (prev_stream && ans8) raw8++;
        if (prev_stream && ans2) raw2++;
        if (cyc == report_at) begin
          exp_src = pk_src;
          exp_h8  = (raw8 > 255) ? 255 : raw8;
          exp_h2  = (raw2 > 3) ? 3 : raw2;
        end
        e_rdy = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e_num = (owner >= 0) ? (vld[owner] ? nm[owner] : hold) : 2'b00;
        chk("ready8", rdy8, e_rdy);
        chk("ready2", rdy2, e_rdy);
        chk("det_num8", det_num8, e_num);
        chk("det_num2", det_num2, e_num);
        chk("done_valid8", done_v8, cyc == report_at);
        chk("done_valid2", done_v2, cyc == report_at);
        chk("done_src8", done_s8, exp_src);
        chk("done_src2", done_s2, exp_src);
        chk("done_hits8", done_h8, exp_h8);
        chk("done_hits2", done_h2, exp_h2);

        if (done_v8) begin
          if (rep_n < 16) begin
            rep_src[rep_n] = done_s8; rep_h8[rep_n] = done_h8;
            rep_h2[rep_n] = done_h2;  rep_lat[rep_n] = cyc - last_acc_cyc;
          end
          rep_n++;
        end
        for (int r = 0; r < 2; r++) begin
          if (acc[r]) begin
            n_acc[r]++;
            if (next_first && last_acc_cyc >= 0 && ovh_n < 16) begin
              ovh[ovh_n] = cyc - last_acc_cyc;
              ovh_n++;
            end
            next_first = lst[r];
            if (lst[r]) last_acc_cyc = cyc;
          end
        end

        prev_stream = (owner >= 0);
        if (owner >= 0) begin
          if (vld[owner]) begin
            hold = nm[owner];
            if (lst[owner]) begin
              report_at = cyc + FLUSH_LEN + 1;
              free_at   = report_at + 1;
              owner     = -1;
            end
          end
        end else if (cyc >= free_at && (vld[0] || vld[1])) begin
          g = (vld[0] && vld[1]) ? !last_srv : vld[1];
          owner = g; last_srv = g; pk_src = g;
          hold = 2'b00; raw8 = 0; raw2 = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_reps(input int n);
    int b = 0;
    while (rep_n < n && b < 400) begin @(posedge clk); b++; end
    chk("report_timeout", rep_n >= n, 1);
  endtask

  int exp_src_l[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 1};
  int exp_h8_l[9]  = '{1, 1, 1, 1, 1, 2, 5, 0, 1};
  int exp_h2_l[9]  = '{1, 1, 1, 1, 1, 2, 3, 0, 1};

  initial begin
    int base;
    int b;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Both requesters busy with 2-symbol packets: grants must alternate 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      push(0, 2'd1, 1'b0, 0); push(0, 2'd3, 1'b1, 0);
      push(1, 2'd2, 1'b0, 0); push(1, 2'd3, 1'b1, 0);
    end
    wait_reps(4);

    push(0, 2'd1, 1'b0, 0); push(0, 2'd1, 1'b0, 0);
    push(0, 2'd2, 1'b0, 0); push(0, 2'd3, 1'b1, 0);
    wait_reps(5);

    // Three-cycle valid gap after the first symbol; the held 3 must not add a hit.
    push(1, 2'd3, 1'b0, 0); push(1, 2'd1, 1'b0, 3);
    push(1, 2'd2, 1'b0, 0); push(1, 2'd3, 1'b1, 0);
    wait_reps(6);

    for (int k = 0; k < 4; k++) begin
      push(0, 2'd3, 1'b0, 0); push(0, 2'd1, 1'b0, 0);
    end
    push(0, 2'd3, 1'b1, 0);
    wait_reps(7);

    // Spurious answers while idle must be ignored.
    repeat (2) @(posedge clk);
    #2 ans_force = 1'b1;
    repeat (2) @(posedge clk);
    #2 ans_force = 1'b0;
    push(1, 2'd1, 1'b0, 0); push(1, 2'd2, 1'b1, 0);
    wait_reps(8);

    // Reset in the middle of a packet: no report, then a single-symbol packet.
    base = n_acc[0];
    for (int k = 0; k < 4; k++) begin
      push(0, 2'd1, 1'b0, 0); push(0, 2'd2, 1'b0, 0);
    end
    push(0, 2'd3, 1'b1, 0);
    b = 0;
    while (n_acc[0] < base + 3 && b < 100) begin @(posedge clk); b++; end
    chk("midpkt_accepts", n_acc[0] >= base + 3, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("no_report_after_reset", rep_n, 8);
    push(1, 2'd3, 1'b1, 0);
    wait_reps(9);
    repeat (4) @(posedge clk);

    chk("report_count", rep_n, 9);
    for (int k = 0; k < 9; k++) begin
      if (k < rep_n) begin
        chk($sformatf("lit_src%0d", k), rep_src[k], exp_src_l[k]);
        chk($sformatf("lit_hits8_%0d", k), rep_h8[k], exp_h8_l[k]);
        chk($sformatf("lit_hits2_%0d", k), rep_h2[k], exp_h2_l[k]);
        chk($sformatf("lit_latency%0d", k), rep_lat[k], FLUSH_LEN + 1);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (k < ovh_n) chk($sformatf("lit_overhead%0d", k), ovh[k], FLUSH_LEN + 3);
    end
    chk("overhead_samples", ovh_n >= 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
